// File: rtl/svm_model_sender_if.sv
// Handshake bundle for svm_model_sender: start/command, coefficient stream in, byte stream out.
// master is the sender side, slave is the host/transmitter side.
interface svm_model_sender_if;
  logic               start_in;
  logic [7:0]         num_supports_in;
  logic signed [31:0] offset_in;
  logic signed [15:0] coef_data_in;
  logic               coef_valid_in;
  logic               coef_ready_out;
  logic [7:0]         byte_data_out;
  logic               byte_valid_out;
  logic               byte_ready_in;
  logic               busy_out;
  logic               done_out;
  logic               error_out;

  modport master (
    input  start_in,
    input  num_supports_in,
    input  offset_in,
    input  coef_data_in,
    input  coef_valid_in,
    output coef_ready_out,
    output byte_data_out,
    output byte_valid_out,
    input  byte_ready_in,
    output busy_out,
    output done_out,
    output error_out
  );

  modport slave (
    output start_in,
    output num_supports_in,
    output offset_in,
    output coef_data_in,
    output coef_valid_in,
    input  coef_ready_out,
    input  byte_data_out,
    input  byte_valid_out,
    output byte_ready_in,
    input  busy_out,
    input  done_out,
    input  error_out
  );
endinterface

// File: rtl/svm_model_sender.sv
// Serializes a linear-SVM model (count, coefficients 1..N-1 per vector, offset) into a
// big-endian byte stream for the classifier loader.
module svm_model_sender #(
  parameter int unsigned NUM_FEATURES_IN = 16
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  svm_model_sender_if.master bus
);

  localparam int unsigned FeatW = (NUM_FEATURES_IN > 2) ? $clog2(NUM_FEATURES_IN) : 1;
  localparam logic [FeatW-1:0] FeatFirst = FeatW'(1);
  localparam logic [FeatW-1:0] FeatLast  = FeatW'(NUM_FEATURES_IN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSendCount,
    StLoadCoef,
    StSendHi,
    StSendLo,
    StSendOffset
  } state_e;

  state_e           state_q, state_d;
  logic             init_q;
  logic [7:0]       count_q, count_d;
  logic [7:0]       s_q, s_d;
  logic [FeatW-1:0] f_q, f_d;
  logic [15:0]      coef_q, coef_d;
  logic [31:0]      offset_q, offset_d;
  logic [1:0]       idx_q, idx_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // init_q blocks starts on the first edge after reset release.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      init_q   <= 1'b0;
      count_q  <= 8'h00;
      s_q      <= 8'h00;
      f_q      <= FeatFirst;
      coef_q   <= 16'h0000;
      offset_q <= 32'h0000_0000;
      idx_q    <= 2'd0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      init_q   <= 1'b1;
      count_q  <= count_d;
      s_q      <= s_d;
      f_q      <= f_d;
      coef_q   <= coef_d;
      offset_q <= offset_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    s_d      = s_q;
    f_d      = f_q;
    coef_d   = coef_q;
    offset_d = offset_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (init_q && bus.start_in) begin
          if (bus.num_supports_in != 8'h00) begin
            state_d  = StSendCount;
            count_d  = bus.num_supports_in;
            offset_d = bus.offset_in;
            s_d      = 8'h00;
            f_d      = FeatFirst;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StSendCount: begin
        if (bus.byte_ready_in) state_d = StLoadCoef;
      end
      StLoadCoef: begin
        if (bus.coef_valid_in) begin
          coef_d  = bus.coef_data_in;
          state_d = StSendHi;
        end
      end
      StSendHi: begin
        if (bus.byte_ready_in) state_d = StSendLo;
      end
      StSendLo: begin
        if (bus.byte_ready_in) begin
          if (f_q != FeatLast) begin
            f_d     = f_q + FeatFirst;
            state_d = StLoadCoef;
          end else if (s_q != (count_q - 8'd1)) begin
            s_d     = s_q + 8'd1;
            f_d     = FeatFirst;
            state_d = StLoadCoef;
          end else begin
            idx_d   = 2'd0;
            state_d = StSendOffset;
          end
        end
      end
      StSendOffset: begin
        if (bus.byte_ready_in) begin
          if (idx_q == 2'd3) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are pure state decodes, so data stays put for as long as a byte is stalled.
  always_comb begin
    bus.byte_valid_out = 1'b0;
    bus.coef_ready_out = 1'b0;
    bus.byte_data_out  = 8'h00;
    unique case (state_q)
      StIdle: ;
      StSendCount: begin
        bus.byte_valid_out = 1'b1;
        bus.byte_data_out  = count_q;
      end
      StLoadCoef: bus.coef_ready_out = 1'b1;
      StSendHi: begin
        bus.byte_valid_out = 1'b1;
        bus.byte_data_out  = coef_q[15:8];
      end
      StSendLo: begin
        bus.byte_valid_out = 1'b1;
        bus.byte_data_out  = coef_q[7:0];
      end
      StSendOffset: begin
        bus.byte_valid_out = 1'b1;
        unique case (idx_q)
          2'd0:    bus.byte_data_out = offset_q[31:24];
          2'd1:    bus.byte_data_out = offset_q[23:16];
          2'd2:    bus.byte_data_out = offset_q[15:8];
          default: bus.byte_data_out = offset_q[7:0];
        endcase
      end
      default: ;
    endcase
    bus.busy_out  = (state_q != StIdle);
    bus.done_out  = done_q;
    bus.error_out = error_q;
  end

endmodule

// File: tb/tb_svm_model_sender.sv
// Bench for svm_model_sender: stream-position model checked every cycle plus directed
// literal expectations for nominal, backpressure, zero count, busy start, reset and max size.
module tb_svm_model_sender;
  localparam int unsigned N = 16;
  localparam int CoefPerVec = N - 1;

  logic clk;
  logic rst_n;
  svm_model_sender_if bus ();

  svm_model_sender #(.NUM_FEATURES_IN(N)) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Coefficient source and randomised handshake driver
  logic [15:0] src[$];
  int src_idx = 0;
  int valid_pct = 100;
  int ready_pct = 100;

  initial begin : driver
    bit hs;
    forever begin
      @(negedge clk);
      hs = bus.coef_ready_out && bus.coef_valid_in;
      @(posedge clk);
      #2;
      if (hs) src_idx++;
      bus.coef_valid_in = (src_idx < src.size()) && ($urandom_range(99) < valid_pct);
      bus.coef_data_in  = (src_idx < src.size()) ? src[src_idx] : 16'h0000;
      bus.byte_ready_in = ($urandom_range(99) < ready_pct);
    end
  end

  // Model: expected stream as a byte list, tracked by stream position p and coefs fetched c.
  logic [7:0] exp_b[$];
  logic [7:0] rx[$];
  bit m_active = 0, m_done = 0, m_error = 0, m_init = 0;
  int m_p = 0, m_c = 0, m_k = 0;
  bit prev_stall = 0;
  logic [7:0] prev_data;
  int done_cnt = 0, done_cyc = 0;

  initial begin : compare
    bit loading, exp_valid, nxt_done, nxt_err;
    logic [31:0] off;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outs", 32'({bus.byte_valid_out, bus.coef_ready_out, bus.busy_out,
                               bus.done_out, bus.error_out, bus.byte_data_out}), 32'd0);
        m_active = 0; m_done = 0; m_error = 0; m_init = 0; prev_stall = 0;
        rx.delete();
      end else begin
        loading = m_active && (m_p >= 1) && (m_p <= 2 * m_k) && ((m_p - 1) % 2 == 0) &&
                  (m_c == (m_p - 1) / 2);
        exp_valid = m_active && !loading;
        chk("busy", 32'(bus.busy_out), 32'(m_active));
        chk("done", 32'(bus.done_out), 32'(m_done));
        chk("error", 32'(bus.error_out), 32'(m_error));
        chk("byte_valid", 32'(bus.byte_valid_out), 32'(exp_valid));
        chk("coef_ready", 32'(bus.coef_ready_out), 32'(loading));
        if (prev_stall) chk("hold_data", 32'(bus.byte_data_out), 32'(prev_data));
        if (exp_valid) chk("byte_data", 32'(bus.byte_data_out), 32'(exp_b[m_p]));
        if (bus.done_out) begin
          done_cnt++;
          done_cyc = cyc;
        end
        prev_stall = bus.byte_valid_out && !bus.byte_ready_in;
        prev_data  = bus.byte_data_out;
        nxt_done = 0;
        nxt_err  = 0;
        if (m_active) begin
          if (exp_valid && bus.byte_ready_in) begin
            rx.push_back(bus.byte_data_out);
            m_p++;
            if (m_p == exp_b.size()) begin
              m_active = 0;
              nxt_done = 1;
            end
          end
          if (loading && bus.coef_valid_in) m_c++;
        end else if (m_init && bus.start_in) begin
          if (bus.num_supports_in != 8'h00) begin
            m_k = CoefPerVec * int'(bus.num_supports_in);
            off = bus.offset_in;
            exp_b.delete();
            exp_b.push_back(bus.num_supports_in);
            for (int i = 0; i < m_k; i++) begin
              exp_b.push_back(src[i][15:8]);
              exp_b.push_back(src[i][7:0]);
            end
            exp_b.push_back(off[31:24]);
            exp_b.push_back(off[23:16]);
            exp_b.push_back(off[15:8]);
            exp_b.push_back(off[7:0]);
            m_p = 0; m_c = 0; m_active = 1;
            rx.delete();
          end else begin
            nxt_err = 1;
          end
        end
        m_done  = nxt_done;
        m_error = nxt_err;
        m_init  = 1;
      end
    end
  end

  int t0 = 0;

  task automatic start_xfer(input logic [7:0] s, input logic [31:0] off);
    @(posedge clk);
    #1;
    src_idx = 0;
    bus.start_in = 1'b1;
    bus.num_supports_in = s;
    bus.offset_in = off;
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.start_in = 1'b0;
    bus.num_supports_in = 8'hAA;   // later input changes must not matter
    bus.offset_in = 32'hA5A5_5A5A;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic loopback(input string name, input int k, input logic [31:0] off);
    int bad = 0;
    for (int i = 0; i < k; i++) if ({rx[1 + 2 * i], rx[2 + 2 * i]} !== src[i]) bad++;
    chk({name, "_coefs"}, 32'(bad), 32'd0);
    chk({name, "_offset"}, {rx[1 + 2 * k], rx[2 + 2 * k], rx[3 + 2 * k], rx[4 + 2 * k]}, off);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int dc0;
    rst_n = 1'b0;
    bus.start_in = 1'b0;
    bus.num_supports_in = 8'h00;
    bus.offset_in = 32'h0;
    bus.coef_data_in = 16'h0;
    bus.coef_valid_in = 1'b0;
    bus.byte_ready_in = 1'b0;
    #23 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Nominal N=16, S=1
    src.delete();
    for (int i = 0; i < 15; i++) src.push_back({8'(2 * i + 1), 8'(2 * i + 2)});
    start_xfer(8'd1, 32'h1122_3344);
    wait_done(200, "nominal");
    chk("nom_len", 32'(rx.size()), 32'd35);
    chk("nom_b0", 32'(rx[0]), 32'h01);
    chk("nom_b1", 32'(rx[1]), 32'h01);
    chk("nom_b2", 32'(rx[2]), 32'h02);
    chk("nom_b29", 32'(rx[29]), 32'h1D);
    chk("nom_b30", 32'(rx[30]), 32'h1E);
    chk("nom_off", {rx[31], rx[32], rx[33], rx[34]}, 32'h1122_3344);
    chk("nom_cycles", 32'(done_cyc - t0), 32'd50);
    #1;
    chk("nom_done_pulse", 32'(bus.done_out), 32'd0);
    chk("nom_busy_fall", 32'(bus.busy_out), 32'd0);

    // Zero count
    @(posedge clk);
    #1;
    bus.start_in = 1'b1;
    bus.num_supports_in = 8'h00;
    @(posedge clk);
    #1;
    bus.start_in = 1'b0;
    chk("zero_err", 32'(bus.error_out), 32'd1);
    chk("zero_busy", 32'(bus.busy_out), 32'd0);
    chk("zero_valid", 32'(bus.byte_valid_out), 32'd0);
    @(posedge clk);
    #1;
    chk("zero_err_end", 32'(bus.error_out), 32'd0);

    // Backpressure, S=2
    src.delete();
    for (int i = 0; i < 30; i++) src.push_back(16'(i * 16'h0911 + 16'h0007));
    valid_pct = 50;
    ready_pct = 30;
    start_xfer(8'd2, 32'hFEDC_BA98);
    wait_done(3000, "backpressure");
    chk("bp_len", 32'(rx.size()), 32'd65);
    chk("bp_b0", 32'(rx[0]), 32'h02);
    loopback("bp", 30, 32'hFEDC_BA98);
    valid_pct = 100;
    ready_pct = 100;

    // Start while busy is ignored
    src.delete();
    for (int i = 0; i < 15; i++) src.push_back(16'hA000 + 16'(i));
    start_xfer(8'd1, 32'hDEAD_BEEF);
    repeat (10) @(posedge clk);
    #1;
    bus.start_in = 1'b1;
    bus.num_supports_in = 8'd3;
    bus.offset_in = 32'h0102_0304;
    @(posedge clk);
    #1;
    bus.start_in = 1'b0;
    wait_done(200, "busy_start");
    chk("bs_len", 32'(rx.size()), 32'd35);
    chk("bs_b0", 32'(rx[0]), 32'h01);
    chk("bs_off", {rx[31], rx[32], rx[33], rx[34]}, 32'hDEAD_BEEF);

    // Reset during SEND_LO of vector 0
    src.delete();
    for (int i = 0; i < 15; i++) src.push_back({8'(2 * i + 1), 8'(2 * i + 2)});
    start_xfer(8'd1, 32'h1122_3344);
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_valid", 32'(bus.byte_valid_out), 32'd1);
    chk("pre_rst_lo", 32'(bus.byte_data_out), 32'h02);
    dc0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.byte_valid_out), 32'd0);
    chk("rst_cready", 32'(bus.coef_ready_out), 32'd0);
    chk("rst_busy", 32'(bus.busy_out), 32'd0);
    chk("rst_done", 32'(bus.done_out), 32'd0);
    chk("rst_error", 32'(bus.error_out), 32'd0);
    chk("rst_data", 32'(bus.byte_data_out), 32'd0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    src_idx = 0;
    bus.start_in = 1'b1;
    bus.num_supports_in = 8'd1;
    bus.offset_in = 32'h5566_7788;
    @(posedge clk);
    #1;
    chk("rel_edge1_busy", 32'(bus.busy_out), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_edge2_busy", 32'(bus.busy_out), 32'd1);
    bus.start_in = 1'b0;
    chk("rst_no_done", 32'(done_cnt - dc0), 32'd0);
    wait_done(200, "post_reset");
    chk("pr_len", 32'(rx.size()), 32'd35);
    chk("pr_b1", 32'(rx[1]), 32'h01);
    chk("pr_off", {rx[31], rx[32], rx[33], rx[34]}, 32'h5566_7788);

    // Maximum S=255
    src.delete();
    for (int i = 0; i < 255 * CoefPerVec; i++) src.push_back(16'(i * 40503 + 12345));
    dc0 = done_cnt;
    start_xfer(8'd255, 32'h7A5B_3C1D);
    wait_done(20000, "max");
    repeat (4) @(posedge clk);
    chk("max_len", 32'(rx.size()), 32'd7655);
    chk("max_b0", 32'(rx[0]), 32'hFF);
    chk("max_last4", {rx[7651], rx[7652], rx[7653], rx[7654]}, 32'h7A5B_3C1D);
    chk("max_one_done", 32'(done_cnt - dc0), 32'd1);
    loopback("max", 255 * CoefPerVec, 32'h7A5B_3C1D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
